sonar_ranger: RTL and testbench

- Sequences the ultrasonic ranging resource (TRIGGER output, ECHO input) on the BlackIce Murax board in hardware, replacing software bit-banging of the GPIO trigger line.
- Issues a trigger pulse, waits for the echo, measures echo high time in microseconds and reports the result with a done pulse.
- Supports single-shot and continuous ranging, enforces a minimum hold-off between shots, and times out on a missing or stuck echo.
- Sits beside MuraxArduino on io_mainClk. Its result registers are read through the GPIO/APB side.

---
 rtl/sonar_ranger_if.sv | 34 +++
 rtl/sonar_ranger.sv | 141 ++++++++++++++
 tb/tb_sonar_ranger.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sonar_ranger_if.sv
// Ranging request/result bundle between the GPIO side and sonar_ranger.
// The slave side is the ranger itself; the master side is its user.
interface sonar_ranger_if;
    logic        io_start;
    logic        io_continuous;
    logic        io_echo;
    logic        io_trigger;
    logic        io_busy;
    logic        io_done;
    logic [15:0] io_width_us;
    logic        io_timeout;

    modport slave (
        input  io_start,
        input  io_continuous,
        input  io_echo,
        output io_trigger,
        output io_busy,
        output io_done,
        output io_width_us,
        output io_timeout
    );

    modport master (
        output io_start,
        output io_continuous,
        output io_echo,
        input  io_trigger,
        input  io_busy,
        input  io_done,
        input  io_width_us,
        input  io_timeout
    );
endinterface

// File: rtl/sonar_ranger.sv
// Ultrasonic ranger sequencer: trigger pulse, echo wait, echo width in us,
// done pulse, hold-off, with single-shot and continuous modes.
module sonar_ranger #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int TRIG_US     = 10,
    parameter int TIMEOUT_US  = 30000,
    parameter int HOLDOFF_US  = 60000
) (
    input  logic          io_mainClk,
    input  logic          io_resetn,
    sonar_ranger_if.slave bus
);

    localparam int CYC      = CLK_FREQ_HZ / 1000000;
    localparam int TRIG_CYC = TRIG_US * CYC;
    localparam int TO_CYC   = TIMEOUT_US * CYC;
    localparam int HO_CYC   = HOLDOFF_US * CYC;
    localparam int MAX_US   = (TRIG_US > TIMEOUT_US)
                            ? ((TRIG_US > HOLDOFF_US) ? TRIG_US : HOLDOFF_US)
                            : ((TIMEOUT_US > HOLDOFF_US) ? TIMEOUT_US : HOLDOFF_US);
    localparam int CW       = $clog2(MAX_US * CYC + 1);
    localparam int PW       = $clog2(CYC);

    localparam logic [CW-1:0] TRIG_END = CW'(TRIG_CYC - 1);
    localparam logic [CW-1:0] TO_END   = CW'(TO_CYC - 1);
    // Hold-off counts the done cycle too, giving one extra cycle before IDLE.
    localparam logic [CW-1:0] HO_END   = CW'(HO_CYC);
    localparam logic [PW-1:0] PRE_END  = PW'(CYC - 1);
    localparam logic [15:0]   TO_US    = 16'(TIMEOUT_US);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRIG    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_MEASURE = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cyc_cnt;
    logic [PW-1:0] pre_cnt;
    logic [15:0]   us_cnt;
    logic          echo_m;
    logic          echo_s;
    logic          echo_d;
    logic          done_r;
    logic [15:0]   width_r;
    logic          timeout_r;

    logic        rise;
    logic        fall;
    logic        wrap;
    logic [15:0] us_nxt;

    assign rise   = echo_s & ~echo_d;
    assign fall   = ~echo_s & echo_d;
    assign wrap   = (pre_cnt == PRE_END);
    assign us_nxt = us_cnt + {15'd0, wrap};

    assign bus.io_trigger  = (state == S_TRIG);
    assign bus.io_busy     = (state != S_IDLE);
    assign bus.io_done     = done_r;
    assign bus.io_width_us = width_r;
    assign bus.io_timeout  = timeout_r;

    always_ff @(posedge io_mainClk) begin
        if (!io_resetn) begin
            state     <= S_IDLE;
            cyc_cnt   <= '0;
            pre_cnt   <= '0;
            us_cnt    <= '0;
            echo_m    <= 1'b0;
            echo_s    <= 1'b0;
            echo_d    <= 1'b0;
            done_r    <= 1'b0;
            width_r   <= '0;
            timeout_r <= 1'b0;
        end else begin
            echo_m <= bus.io_echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.io_start | bus.io_continuous) begin
                        state   <= S_TRIG;
                        cyc_cnt <= '0;
                    end
                end
                S_TRIG: begin
                    if (cyc_cnt == TRIG_END) begin
                        state   <= S_WAIT;
                        cyc_cnt <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (rise) begin
                        state   <= S_MEASURE;
                        pre_cnt <= '0;
                        us_cnt  <= '0;
                    end else if (cyc_cnt == TO_END) begin
                        width_r   <= '0;
                        timeout_r <= 1'b1;
                        done_r    <= 1'b1;
                        state     <= S_HOLDOFF;
                        cyc_cnt   <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                S_MEASURE: begin
                    pre_cnt <= wrap ? '0 : pre_cnt + PW'(1);
                    us_cnt  <= us_nxt;
                    // A fall coinciding with the final wrap still counts as a clean echo.
                    if (fall) begin
                        width_r   <= us_nxt;
                        timeout_r <= 1'b0;
                        done_r    <= 1'b1;
                        state     <= S_HOLDOFF;
                        cyc_cnt   <= '0;
                    end else if (wrap && us_nxt == TO_US) begin
                        width_r   <= TO_US;
                        timeout_r <= 1'b1;
                        done_r    <= 1'b1;
                        state     <= S_HOLDOFF;
                        cyc_cnt   <= '0;
                    end
                end
                S_HOLDOFF: begin
                    if (cyc_cnt == HO_END) begin
                        state <= S_IDLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sonar_ranger.sv
// Scoreboard bench for sonar_ranger with CYC=4, 10us trigger,
// 100us timeout and 50us hold-off.
module tb_sonar_ranger;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sonar_ranger_if bus();

    sonar_ranger #(
        .CLK_FREQ_HZ(4000000),
        .TRIG_US(10),
        .TIMEOUT_US(100),
        .HOLDOFF_US(50)
    ) dut (
        .io_mainClk(clk),
        .io_resetn(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [16:0] exp_q[$];
    logic [16:0] exp_v;
    int rise_t[$];
    int done_t[$];
    logic trig_prev = 1'b0;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc++;

    // Scoreboard: every done pulse consumes one expected {width, timeout}.
    always @(negedge clk) begin
        if (bus.io_trigger === 1'b1 && trig_prev !== 1'b1) rise_t.push_back(cyc);
        trig_prev = bus.io_trigger;
        if (bus.io_done === 1'b1) begin
            done_cnt++;
            done_t.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result: unexpected done width=%0d timeout=%0b",
                         bus.io_width_us, bus.io_timeout);
            end else begin
                exp_v = exp_q.pop_front();
                if ({bus.io_width_us, bus.io_timeout} !== exp_v) begin
                    errors++;
                    $display("FAIL result: got width=%0d timeout=%0b want width=%0d timeout=%0b",
                             bus.io_width_us, bus.io_timeout, exp_v[16:1], exp_v[0]);
                end
            end
            checks++;
            if (done_prev !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse: done high %0b cycles in a row, want 1", done_prev);
            end
        end
        done_prev = bus.io_done;
    end

    task automatic fire();
        int n;
        @(negedge clk) bus.io_start = 1'b1;
        @(negedge clk) bus.io_start = 1'b0;
        checks++;
        if ({bus.io_trigger, bus.io_busy} !== 2'b11) begin
            errors++;
            $display("FAIL trig_start: trigger/busy=%b want 11",
                     {bus.io_trigger, bus.io_busy});
        end
        n = 0;
        while (bus.io_trigger === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 40) begin
            errors++;
            $display("FAIL trig_width: got %0d cycles want 40", n);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.io_done !== 1'b1 && n < 1000);
        if (bus.io_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_wait: no done within %0d cycles", n);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.io_busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (bus.io_busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_wait: busy still %b after %0d cycles", bus.io_busy, n);
        end
    endtask

    task automatic test_reset();
        bus.io_start = 1'b0;
        bus.io_continuous = 1'b0;
        bus.io_echo = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.io_trigger, bus.io_busy, bus.io_done, bus.io_timeout} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.io_trigger, bus.io_busy, bus.io_done, bus.io_timeout});
        end
        checks++;
        if (bus.io_width_us !== 16'd0) begin
            errors++;
            $display("FAIL reset_width: got %0d want 0", bus.io_width_us);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.io_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b want 0", bus.io_busy);
        end
    endtask

    task automatic test_echo_width(input int high, input int w);
        int d0;
        d0 = done_cnt;
        fire();
        exp_q.push_back({16'(w), 1'b0});
        repeat (20) @(negedge clk);
        bus.io_echo = 1'b1;
        repeat (high) @(negedge clk);
        bus.io_echo = 1'b0;
        wait_idle();
        checks++;
        if (done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL echo_done_count: got %0d want %0d", done_cnt - d0, 1);
        end
    endtask

    task automatic test_no_echo();
        int n;
        int k;
        fire();
        exp_q.push_back({16'd0, 1'b1});
        wait_done(n);
        checks++;
        if (n !== 400) begin
            errors++;
            $display("FAIL timeout_latency: got %0d want 400", n);
        end
        k = 0;
        @(negedge clk);
        while (bus.io_busy === 1'b1 && k < 1000) begin
            k++;
            @(negedge clk);
        end
        checks++;
        if (k !== 200) begin
            errors++;
            $display("FAIL holdoff_len: got %0d want 200", k);
        end
    endtask

    task automatic test_stuck_echo();
        int d0;
        int n;
        d0 = done_cnt;
        bus.io_echo = 1'b1;
        repeat (5) @(negedge clk);
        fire();
        exp_q.push_back({16'd0, 1'b1});
        wait_idle();
        bus.io_echo = 1'b0;
        repeat (5) @(negedge clk);
        fire();
        exp_q.push_back({16'd100, 1'b1});
        repeat (20) @(negedge clk);
        bus.io_echo = 1'b1;
        wait_done(n);
        bus.io_echo = 1'b0;
        wait_idle();
        checks++;
        if (done_cnt !== d0 + 2) begin
            errors++;
            $display("FAIL stuck_done_count: got %0d want 2", done_cnt - d0);
        end
    endtask

    task automatic test_continuous();
        int r0;
        int d0;
        int n;
        r0 = rise_t.size();
        d0 = done_t.size();
        @(negedge clk) bus.io_continuous = 1'b1;
        for (int s = 0; s < 3; s++) begin
            n = 0;
            while (bus.io_trigger !== 1'b1 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            n = 0;
            while (bus.io_trigger === 1'b1 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            exp_q.push_back({16'd25, 1'b0});
            repeat (20) @(negedge clk);
            bus.io_echo = 1'b1;
            bus.io_start = 1'b1;
            @(negedge clk) bus.io_start = 1'b0;
            repeat (99) @(negedge clk);
            if (s == 2) bus.io_continuous = 1'b0;
            bus.io_echo = 1'b0;
            wait_done(n);
        end
        wait_idle();
        repeat (300) @(negedge clk);
        checks++;
        if (rise_t.size() - r0 !== 3) begin
            errors++;
            $display("FAIL cont_shots: got %0d trigger rises want 3", rise_t.size() - r0);
        end
        checks++;
        if (done_t.size() - d0 !== 3) begin
            errors++;
            $display("FAIL cont_results: got %0d dones want 3", done_t.size() - d0);
        end
        for (int i = 0; i < 2; i++) begin
            if (rise_t.size() > r0 + i + 1 && done_t.size() > d0 + i) begin
                checks++;
                if (rise_t[r0+i+1] - done_t[d0+i] !== 202) begin
                    errors++;
                    $display("FAIL cont_spacing%0d: got %0d want 202",
                             i, rise_t[r0+i+1] - done_t[d0+i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        fire();
        repeat (20) @(negedge clk);
        bus.io_echo = 1'b1;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        checks++;
        if ({bus.io_trigger, bus.io_busy, bus.io_done, bus.io_timeout} !== 4'b0) begin
            errors++;
            $display("FAIL midreset_flags: got %b want 0000",
                     {bus.io_trigger, bus.io_busy, bus.io_done, bus.io_timeout});
        end
        checks++;
        if (bus.io_width_us !== 16'd0) begin
            errors++;
            $display("FAIL midreset_width: got %0d want 0", bus.io_width_us);
        end
        bus.io_echo = 1'b0;
        repeat (100) @(negedge clk);
        checks++;
        if (done_cnt !== d0 || bus.io_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: dones=%0d busy=%b want 0 0",
                     done_cnt - d0, bus.io_busy);
        end
        test_echo_width(100, 25);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_echo_width(232, 58);
        test_echo_width(235, 58);
        test_echo_width(236, 59);
        test_no_echo();
        test_stuck_echo();
        test_continuous();
        test_reset_mid();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never produced", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
